// File: rtl/cpu_types_pkg.sv
// Shared CPU fetch-stage types.
//   word_t            : default 32-bit machine word
//   pcsrc_t           : next-PC source select encoding
//   RAS_DEPTH_DEFAULT : default return-address-stack depth
package cpu_types_pkg;

  localparam int unsigned WORD_W            = 32;
  localparam int unsigned RAS_DEPTH_DEFAULT = 4;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    PC_SEQ = 2'd0,
    PC_BR  = 2'd1,
    PC_J   = 2'd2,
    PC_JR  = 2'd3
  } pcsrc_t;

endpackage

// File: rtl/ras_stack.sv
// Circular LIFO of return addresses with push/pop/replace.
//   clk, rst        : clock, synchronous active-high reset
//   i_push, i_pop   : operation requests (both = replace top)
//   i_din           : value to push
//   o_top           : top entry, 0 when empty
//   o_count         : number of valid entries
//   o_overflow      : sticky, push while full
//   o_underflow     : sticky, pop while empty
module ras_stack #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_din,
  output logic [WIDTH-1:0]         o_top,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_overflow,
  output logic                     o_underflow
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_sp;
  logic [CW-1:0]    r_count;
  logic             r_ovf;
  logic             r_unf;

  logic             w_empty;
  logic             w_full;
  logic [PW-1:0]    w_sp_n;
  logic [CW-1:0]    w_cnt_n;
  logic             w_wr;
  logic [PW-1:0]    w_wr_idx;
  logic             w_ovf_n;
  logic             w_unf_n;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(DEPTH));

  // Next pointer/count/flags. A pop on a non-empty stack is resolved first;
  // if a push accompanies it the top slot is simply overwritten.
  always_comb begin
    w_sp_n   = r_sp;
    w_cnt_n  = r_count;
    w_wr     = 1'b0;
    w_wr_idx = r_sp;
    w_ovf_n  = r_ovf;
    w_unf_n  = r_unf;
    if (i_pop && !w_empty) begin
      if (i_push) begin
        w_wr     = 1'b1;
        w_wr_idx = r_sp;
      end else begin
        w_sp_n  = r_sp - PW'(1);
        w_cnt_n = r_count - CW'(1);
      end
    end else begin
      if (i_pop) w_unf_n = 1'b1;
      if (i_push) begin
        // When full, sp+1 is the oldest slot, so it is overwritten.
        w_sp_n   = r_sp + PW'(1);
        w_wr     = 1'b1;
        w_wr_idx = r_sp + PW'(1);
        if (w_full) w_ovf_n = 1'b1;
        else        w_cnt_n = r_count + CW'(1);
      end
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sp    <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
    end else begin
      r_sp    <= w_sp_n;
      r_count <= w_cnt_n;
      r_ovf   <= w_ovf_n;
      r_unf   <= w_unf_n;
      if (w_wr) r_mem[w_wr_idx] <= i_din;
    end
  end

  assign o_top       = w_empty ? '0 : r_mem[r_sp];
  assign o_count     = r_count;
  assign o_overflow  = r_ovf;
  assign o_underflow = r_unf;

endmodule

// File: rtl/pc_ras.sv
// Fetch-stage program counter with return-address stack.
//   CLK, RST                 : clock, synchronous active-high reset
//   pc_en, halt              : advance enable, permanent freeze until reset
//   pc_src, branch_taken     : next-PC source select and branch outcome
//   branch_target, imm26     : branch / jump targets
//   regval                   : jr register value
//   is_call, is_ret          : jal push, jr $31 pop
//   imemaddr                 : current PC
//   ras_top, ras_count       : stack top and occupancy
//   ret_mismatch             : one-cycle pulse, predicted return != regval
//   ras_overflow/underflow   : sticky stack error flags
module pc_ras
  import cpu_types_pkg::*;
#(
  parameter int unsigned       WIDTH     = 32,
  parameter logic [WIDTH-1:0]  PC_INIT   = '0,
  parameter int unsigned       RAS_DEPTH = RAS_DEPTH_DEFAULT
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         pc_en,
  input  logic                         halt,
  input  logic [1:0]                   pc_src,
  input  logic                         branch_taken,
  input  logic [WIDTH-1:0]             branch_target,
  input  logic [25:0]                  imm26,
  input  logic [WIDTH-1:0]             regval,
  input  logic                         is_call,
  input  logic                         is_ret,
  output logic [WIDTH-1:0]             imemaddr,
  output logic [WIDTH-1:0]             ras_top,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ret_mismatch,
  output logic                         ras_overflow,
  output logic                         ras_underflow
);

  logic [WIDTH-1:0] r_pc;
  logic             r_halted;
  logic             r_mismatch;

  pcsrc_t           w_src;
  logic             w_adv;
  logic             w_push;
  logic             w_pop;
  logic [WIDTH-1:0] w_pc4;
  logic [WIDTH-1:0] w_pc_n;
  logic             w_mismatch_n;

  assign w_src  = pcsrc_t'(pc_src);
  // halt in the same cycle already blocks the advance.
  assign w_adv  = pc_en && !halt && !r_halted;
  assign w_pc4  = r_pc + WIDTH'(4);
  assign w_push = w_adv && is_call;
  assign w_pop  = w_adv && is_ret && (w_src == PC_JR);

  // Next-PC select.
  always_comb begin
    w_pc_n = r_pc;
    if (w_adv) begin
      case (w_src)
        PC_SEQ:  w_pc_n = w_pc4;
        PC_BR:   w_pc_n = branch_taken ? branch_target : w_pc4;
        PC_J:    w_pc_n = {w_pc4[WIDTH-1:28], imm26, 2'b00};
        PC_JR:   w_pc_n = regval;
        default: w_pc_n = w_pc4;
      endcase
    end
  end

  // Mismatch only for a real pop; compared against the pre-update top.
  assign w_mismatch_n = w_pop && (ras_count != '0) && (ras_top != regval);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_pc       <= PC_INIT;
      r_halted   <= 1'b0;
      r_mismatch <= 1'b0;
    end else begin
      r_pc       <= w_pc_n;
      r_mismatch <= w_mismatch_n;
      if (halt) r_halted <= 1'b1;
    end
  end

  ras_stack #(
    .WIDTH (WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk         (CLK),
    .rst         (RST),
    .i_push      (w_push),
    .i_pop       (w_pop),
    .i_din       (w_pc4),
    .o_top       (ras_top),
    .o_count     (ras_count),
    .o_overflow  (ras_overflow),
    .o_underflow (ras_underflow)
  );

  assign imemaddr     = r_pc;
  assign ret_mismatch = r_mismatch;

endmodule

// File: tb/tb_pc_ras.sv
// Directed vector bench for pc_ras (PC_INIT=0x200, WIDTH=32, RAS_DEPTH=4).
module tb_pc_ras;

  logic        CLK = 1'b0;
  logic        RST;
  logic        pc_en;
  logic        halt;
  logic [1:0]  pc_src;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [25:0] imm26;
  logic [31:0] regval;
  logic        is_call;
  logic        is_ret;
  logic [31:0] imemaddr;
  logic [31:0] ras_top;
  logic [2:0]  ras_count;
  logic        ret_mismatch;
  logic        ras_overflow;
  logic        ras_underflow;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  pc_ras #(
    .WIDTH     (32),
    .PC_INIT   (32'h200),
    .RAS_DEPTH (4)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .pc_en         (pc_en),
    .halt          (halt),
    .pc_src        (pc_src),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imm26         (imm26),
    .regval        (regval),
    .is_call       (is_call),
    .is_ret        (is_ret),
    .imemaddr      (imemaddr),
    .ras_top       (ras_top),
    .ras_count     (ras_count),
    .ret_mismatch  (ret_mismatch),
    .ras_overflow  (ras_overflow),
    .ras_underflow (ras_underflow)
  );

  typedef struct {
    logic        rst;
    logic        en;
    logic        hlt;
    logic [1:0]  src;
    logic        tk;
    logic [31:0] bt;
    logic [25:0] imm;
    logic [31:0] rv;
    logic        call;
    logic        ret;
    logic [31:0] epc;
    logic [2:0]  ecnt;
    logic [31:0] etop;
    logic        em;
    logic        eo;
    logic        eu;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic rst, en, hlt, input logic [1:0] src,
                     input logic tk, input logic [31:0] bt, input logic [25:0] imm,
                     input logic [31:0] rv, input logic call, ret,
                     input logic [31:0] epc, input logic [2:0] ecnt,
                     input logic [31:0] etop, input logic em, eo, eu);
    vec_t v;
    v.rst = rst; v.en = en; v.hlt = hlt; v.src = src; v.tk = tk; v.bt = bt;
    v.imm = imm; v.rv = rv; v.call = call; v.ret = ret;
    v.epc = epc; v.ecnt = ecnt; v.etop = etop; v.em = em; v.eo = eo; v.eu = eu;
    vq.push_back(v);
  endtask

  task automatic drive(input logic rst, en, hlt, input logic [1:0] src,
                       input logic tk, input logic [31:0] bt, input logic [25:0] imm,
                       input logic [31:0] rv, input logic call, ret);
    RST = rst; pc_en = en; halt = hlt; pc_src = src; branch_taken = tk;
    branch_target = bt; imm26 = imm; regval = rv; is_call = call; is_ret = ret;
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got 0x%08h want 0x%08h", name, idx, act, exp);
    end
  endtask

  task automatic chk_all(input int idx, input logic [31:0] epc, input logic [2:0] ecnt,
                         input logic [31:0] etop, input logic em, eo, eu);
    chk("imemaddr",      idx, imemaddr,             epc);
    chk("ras_count",     idx, 32'(ras_count),       32'(ecnt));
    chk("ras_top",       idx, ras_top,              etop);
    chk("ret_mismatch",  idx, 32'(ret_mismatch),    32'(em));
    chk("ras_overflow",  idx, 32'(ras_overflow),    32'(eo));
    chk("ras_underflow", idx, 32'(ras_underflow),   32'(eu));
  endtask

  initial begin
    drive(1, 0, 0, 2'd0, 0, '0, '0, '0, 0, 0);

    //  rst en hl src tk  bt       imm    rv         cl rt   pc          cnt top        m o u
    add(1, 0, 0, 2'd0, 0, 32'h0,   26'h0,  32'h0,        0, 0, 32'h200,      0, 32'h0,   0,0,0);
    add(0, 1, 0, 2'd0, 0, 32'h0,   26'h0,  32'h0,        0, 0, 32'h204,      0, 32'h0,   0,0,0);
    add(0, 1, 0, 2'd0, 0, 32'h0,   26'h0,  32'h0,        0, 0, 32'h208,      0, 32'h0,   0,0,0);
    add(0, 1, 0, 2'd0, 0, 32'h0,   26'h0,  32'h0,        0, 0, 32'h20C,      0, 32'h0,   0,0,0);
    add(0, 0, 0, 2'd1, 1, 32'h400, 26'h0,  32'h0,        0, 0, 32'h20C,      0, 32'h0,   0,0,0);
    add(0, 0, 0, 2'd0, 0, 32'h0,   26'h0,  32'h0,        0, 0, 32'h20C,      0, 32'h0,   0,0,0);
    add(0, 1, 0, 2'd1, 1, 32'h400, 26'h0,  32'h0,        0, 0, 32'h400,      0, 32'h0,   0,0,0);
    add(0, 1, 0, 2'd1, 0, 32'h800, 26'h0,  32'h0,        0, 0, 32'h404,      0, 32'h0,   0,0,0);
    add(0, 1, 0, 2'd3, 0, 32'h0,   26'h0,  32'h1000_0010,0, 0, 32'h1000_0010,0, 32'h0,   0,0,0);
    add(0, 1, 0, 2'd2, 0, 32'h0,   26'h40, 32'h0,        0, 0, 32'h1000_0100,0, 32'h0,   0,0,0);
    add(0, 1, 0, 2'd3, 0, 32'h0,   26'h0,  32'h100,      0, 0, 32'h100,      0, 32'h0,   0,0,0);
    // jal at 0x100 pushes 0x104, then matching and mismatching returns
    add(0, 1, 0, 2'd2, 0, 32'h0,   26'h40, 32'h0,        1, 0, 32'h100,      1, 32'h104, 0,0,0);
    add(0, 1, 0, 2'd3, 0, 32'h0,   26'h0,  32'h104,      0, 1, 32'h104,      0, 32'h0,   0,0,0);
    add(0, 1, 0, 2'd3, 0, 32'h0,   26'h0,  32'h100,      0, 0, 32'h100,      0, 32'h0,   0,0,0);
    add(0, 1, 0, 2'd2, 0, 32'h0,   26'h40, 32'h0,        1, 0, 32'h100,      1, 32'h104, 0,0,0);
    add(0, 1, 0, 2'd3, 0, 32'h0,   26'h0,  32'h108,      0, 1, 32'h108,      0, 32'h0,   1,0,0);
    add(0, 1, 0, 2'd0, 0, 32'h0,   26'h0,  32'h0,        0, 0, 32'h10C,      0, 32'h0,   0,0,0);
    // five pushes 0x10..0x50 into a 4-deep stack
    add(0, 1, 0, 2'd3, 0, 32'h0,   26'h0,  32'hC,        0, 0, 32'hC,        0, 32'h0,   0,0,0);
    add(0, 1, 0, 2'd3, 0, 32'h0,   26'h0,  32'h1C,       1, 0, 32'h1C,       1, 32'h10,  0,0,0);
    add(0, 1, 0, 2'd3, 0, 32'h0,   26'h0,  32'h2C,       1, 0, 32'h2C,       2, 32'h20,  0,0,0);
    add(0, 1, 0, 2'd3, 0, 32'h0,   26'h0,  32'h3C,       1, 0, 32'h3C,       3, 32'h30,  0,0,0);
    add(0, 1, 0, 2'd3, 0, 32'h0,   26'h0,  32'h4C,       1, 0, 32'h4C,       4, 32'h40,  0,0,0);
    add(0, 1, 0, 2'd3, 0, 32'h0,   26'h0,  32'h100,      1, 0, 32'h100,      4, 32'h50,  0,1,0);
    add(0, 1, 0, 2'd3, 0, 32'h0,   26'h0,  32'h50,       0, 1, 32'h50,       3, 32'h40,  0,1,0);
    add(0, 1, 0, 2'd3, 0, 32'h0,   26'h0,  32'h40,       0, 1, 32'h40,       2, 32'h30,  0,1,0);
    add(0, 1, 0, 2'd3, 0, 32'h0,   26'h0,  32'h30,       0, 1, 32'h30,       1, 32'h20,  0,1,0);
    add(0, 1, 0, 2'd3, 0, 32'h0,   26'h0,  32'h20,       0, 1, 32'h20,       0, 32'h0,   0,1,0);
    add(0, 1, 0, 2'd3, 0, 32'h0,   26'h0,  32'h998,      0, 1, 32'h998,      0, 32'h0,   0,1,1);
    // is_ret without jr is ignored
    add(0, 1, 0, 2'd0, 0, 32'h0,   26'h0,  32'h0,        0, 1, 32'h99C,      0, 32'h0,   0,1,1);
    // push + pop in one cycle replaces the top
    add(0, 1, 0, 2'd3, 0, 32'h0,   26'h0,  32'h500,      1, 0, 32'h500,      1, 32'h9A0, 0,1,1);
    add(0, 1, 0, 2'd3, 0, 32'h0,   26'h0,  32'h9A0,      1, 1, 32'h9A0,      1, 32'h504, 0,1,1);
    add(0, 1, 0, 2'd3, 0, 32'h0,   26'h0,  32'h600,      1, 1, 32'h600,      1, 32'h9A4, 1,1,1);
    add(0, 1, 0, 2'd3, 0, 32'h0,   26'h0,  32'h300,      0, 0, 32'h300,      1, 32'h9A4, 0,1,1);
    add(0, 1, 0, 2'd3, 0, 32'h0,   26'h0,  32'h300,      1, 0, 32'h300,      2, 32'h304, 0,1,1);

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].rst, vq[i].en, vq[i].hlt, vq[i].src, vq[i].tk, vq[i].bt,
            vq[i].imm, vq[i].rv, vq[i].call, vq[i].ret);
      @(posedge CLK); #1;
      chk_all(i, vq[i].epc, vq[i].ecnt, vq[i].etop, vq[i].em, vq[i].eo, vq[i].eu);
    end

    // halt + pc_en at 0x300: frozen for 10 cycles even with later enables
    drive(0, 1, 1, 2'd0, 0, '0, '0, '0, 0, 0);
    @(posedge CLK); #1;
    chk_all(100, 32'h300, 3'd2, 32'h304, 0, 1, 1);
    for (int k = 0; k < 9; k++) begin
      drive(0, 1, 0, 2'd3, 0, '0, '0, 32'h700, 1, 1);
      @(posedge CLK); #1;
      chk_all(101 + k, 32'h300, 3'd2, 32'h304, 0, 1, 1);
    end

    // reset mid-stack with everything else asserted
    drive(1, 1, 1, 2'd3, 1, 32'h800, 26'h1, 32'h700, 1, 1);
    @(posedge CLK); #1;
    chk_all(200, 32'h200, 3'd0, 32'h0, 0, 0, 0);

    // halt latch cleared by reset: advances again
    drive(0, 1, 0, 2'd0, 0, '0, '0, '0, 0, 0);
    @(posedge CLK); #1;
    chk_all(201, 32'h204, 3'd0, 32'h0, 0, 0, 0);

    // PC+4 wraps modulo 2^32
    drive(0, 1, 0, 2'd3, 0, '0, '0, 32'hFFFF_FFFC, 0, 0);
    @(posedge CLK); #1;
    chk_all(202, 32'hFFFF_FFFC, 3'd0, 32'h0, 0, 0, 0);
    drive(0, 1, 0, 2'd0, 0, '0, '0, '0, 0, 0);
    @(posedge CLK); #1;
    chk_all(203, 32'h0, 3'd0, 32'h0, 0, 0, 0);

    // mismatch pulse suppressed while stalled
    drive(0, 1, 0, 2'd3, 0, '0, '0, 32'h100, 1, 0);
    @(posedge CLK); #1;
    chk_all(204, 32'h100, 3'd1, 32'h4, 0, 0, 0);
    drive(0, 0, 0, 2'd3, 0, '0, '0, 32'h999, 0, 1);
    @(posedge CLK); #1;
    chk_all(205, 32'h100, 3'd1, 32'h4, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
